// File: rtl/sim_record_formatter_if.sv
// Handshake and data bundle between the SIM reader/LCD controller and sim_record_formatter.
// The master side drives capture/format requests; the slave side is the formatter.
interface sim_record_formatter_if #(
  parameter int unsigned NUM_REC   = 2,
  parameter int unsigned REC_BYTES = 30,
  parameter int unsigned LCD_CHARS = 20
);
  logic                                     Dato_Valido;
  logic [7:0]                               Dato_SIM;
  logic                                     Clear;
  logic                                     Req;
  logic [$clog2(2*NUM_REC)-1:0]             Sel;
  logic [8*LCD_CHARS-1:0]                   Dato_LCD;
  logic                                     Listo;
  logic                                     Ocupado;
  logic                                     Desborde;
  logic [$clog2(NUM_REC*REC_BYTES+1)-1:0]   Bytes_Cont;

  modport master (
    output Dato_Valido, Dato_SIM, Clear, Req, Sel,
    input  Dato_LCD, Listo, Ocupado, Desborde, Bytes_Cont
  );

  modport slave (
    input  Dato_Valido, Dato_SIM, Clear, Req, Sel,
    output Dato_LCD, Listo, Ocupado, Desborde, Bytes_Cont
  );
endinterface

// File: rtl/sim_record_formatter.sv
// SIM record capture buffer plus a one-character-per-cycle fixed-width LCD line formatter.
// Define SIM_FMT_HEX_EN to render number-line nibbles A-F as hex letters instead of '?'/space.
module sim_record_formatter #(
  parameter int unsigned NUM_REC   = 2,
  parameter int unsigned REC_BYTES = 30,
  parameter int unsigned NAME_OFF  = 1,
  parameter int unsigned NAME_LEN  = 12,
  parameter int unsigned NUM_OFF   = 17,
  parameter int unsigned NUM_BYTES = 5,
  parameter int unsigned LCD_CHARS = 20
) (
  input logic                   CLK,
  input logic                   Reset,
  sim_record_formatter_if.slave fmt_if
);

  localparam int unsigned Depth      = NUM_REC * REC_BYTES;
  localparam int unsigned CntW       = $clog2(Depth + 1);
  localparam int unsigned AddrW      = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned SelW       = $clog2(2 * NUM_REC);
  localparam int unsigned IdxW       = (LCD_CHARS > 1) ? $clog2(LCD_CHARS) : 1;
  localparam int unsigned LineW      = 8 * LCD_CHARS;
  localparam int unsigned NamePfxLen = 8;
  localparam int unsigned NumPfxLen  = 3;
  localparam logic [8*NamePfxLen-1:0] NamePfx = "Nombre: ";
  localparam logic [8*NumPfxLen-1:0]  NumPfx  = "#: ";

  typedef enum logic [1:0] {StIdle, StLoad, StEmit, StDone} state_e;

  // Capture path
  logic             sync1_q, sync2_q, sync3_q;
  logic [7:0]       data_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             wr_en;
  logic [7:0]       mem_q [Depth];

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    wr_en = 1'b0;
    // Clear has priority, so a byte arriving in the same cycle is dropped.
    if (fmt_if.Clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (sync2_q && !sync3_q) begin
      if (cnt_q == CntW'(Depth)) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= fmt_if.Dato_Valido;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      data_q  <= fmt_if.Dato_SIM;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[cnt_q[AddrW-1:0]] <= data_q;
  end

  // Formatter
  state_e            state_q, state_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [31:0]       base_q, base_d;
  logic              rec_ok_q, rec_ok_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [LineW-1:0]  shadow_q, shadow_d;
  logic [LineW-1:0]  lcd_q, lcd_d;
  logic              listo_q, listo_d;

  logic [31:0]       idx_w, addr, dig;
  logic [7:0]        rd_byte, ch;

  function automatic logic [7:0] nib_char(input logic [3:0] n);
    if (n <= 4'd9) return 8'h30 + {4'h0, n};
`ifdef SIM_FMT_HEX_EN
    return 8'h37 + {4'h0, n};
`else
    if (n == 4'hF) return 8'h20;
    return 8'h3F;
`endif
  endfunction

  // Character for the current emit position; addresses at or past the fill level show '-'.
  always_comb begin
    idx_w   = 32'(idx_q);
    ch      = 8'h20;
    addr    = '0;
    dig     = '0;
    rd_byte = 8'h00;
    if (rec_ok_q) begin
      if (!sel_q[0]) begin
        if (idx_w < NamePfxLen) begin
          ch = NamePfx[8*(NamePfxLen-1-idx_w) +: 8];
        end else if (idx_w < NamePfxLen + NAME_LEN) begin
          addr = base_q + NAME_OFF + idx_w - NamePfxLen;
          if (addr >= 32'(cnt_q)) begin
            ch = 8'h2D;
          end else begin
            rd_byte = mem_q[addr[AddrW-1:0]];
            ch      = (rd_byte == 8'hFF) ? 8'h20 : rd_byte;
          end
        end
      end else begin
        if (idx_w < NumPfxLen) begin
          ch = NumPfx[8*(NumPfxLen-1-idx_w) +: 8];
        end else if (idx_w < NumPfxLen + 2 * NUM_BYTES) begin
          dig  = idx_w - NumPfxLen;
          addr = base_q + NUM_OFF + (dig >> 1);
          if (addr >= 32'(cnt_q)) begin
            ch = 8'h2D;
          end else begin
            rd_byte = mem_q[addr[AddrW-1:0]];
            ch      = nib_char(dig[0] ? rd_byte[7:4] : rd_byte[3:0]);
          end
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    base_d   = base_q;
    rec_ok_d = rec_ok_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    lcd_d    = lcd_q;
    listo_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (fmt_if.Req) begin
          sel_d   = fmt_if.Sel;
          state_d = StLoad;
        end
      end
      StLoad: begin
        base_d   = 32'(sel_q >> 1) * REC_BYTES;
        rec_ok_d = 32'(sel_q >> 1) < NUM_REC;
        idx_d    = '0;
        state_d  = StEmit;
      end
      StEmit: begin
        shadow_d[8*(LCD_CHARS-1-32'(idx_q)) +: 8] = ch;
        if (idx_q == IdxW'(LCD_CHARS - 1)) state_d = StDone;
        else                               idx_d   = idx_q + 1'b1;
      end
      StDone: begin
        lcd_d   = shadow_q;
        listo_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      base_q   <= '0;
      rec_ok_q <= 1'b0;
      idx_q    <= '0;
      shadow_q <= {LCD_CHARS{8'h20}};
      lcd_q    <= {LCD_CHARS{8'h20}};
      listo_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      base_q   <= base_d;
      rec_ok_q <= rec_ok_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      lcd_q    <= lcd_d;
      listo_q  <= listo_d;
    end
  end

  assign fmt_if.Dato_LCD   = lcd_q;
  assign fmt_if.Listo      = listo_q;
  assign fmt_if.Ocupado    = (state_q != StIdle);
  assign fmt_if.Desborde   = ovf_q;
  assign fmt_if.Bytes_Cont = cnt_q;

endmodule

// File: tb/tb_sim_record_formatter.sv
// Randomized self-checking bench for sim_record_formatter against a queue-based line model.
// A second instance with three records exercises out-of-range record selection.
module tb_sim_record_formatter;

  localparam int unsigned NumRec   = 2;
  localparam int unsigned RecBytes = 30;
  localparam int unsigned NameOff  = 1;
  localparam int unsigned NameLen  = 12;
  localparam int unsigned NumOff   = 17;
  localparam int unsigned NumBytes = 5;
  localparam int unsigned LcdChars = 20;
  localparam int unsigned Depth    = NumRec * RecBytes;
  localparam int unsigned LineW    = 8 * LcdChars;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sim_record_formatter_if #(.NUM_REC(NumRec), .REC_BYTES(RecBytes), .LCD_CHARS(LcdChars)) bus ();
  sim_record_formatter #(
    .NUM_REC(NumRec), .REC_BYTES(RecBytes), .NAME_OFF(NameOff), .NAME_LEN(NameLen),
    .NUM_OFF(NumOff), .NUM_BYTES(NumBytes), .LCD_CHARS(LcdChars)
  ) dut (
    .CLK(clk), .Reset(rst_n), .fmt_if(bus)
  );

  sim_record_formatter_if #(.NUM_REC(3), .REC_BYTES(RecBytes), .LCD_CHARS(LcdChars)) bus3 ();
  sim_record_formatter #(
    .NUM_REC(3), .REC_BYTES(RecBytes), .NAME_OFF(NameOff), .NAME_LEN(NameLen),
    .NUM_OFF(NumOff), .NUM_BYTES(NumBytes), .LCD_CHARS(LcdChars)
  ) dut3 (
    .CLK(clk), .Reset(rst_n), .fmt_if(bus3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned m_mem [Depth];
  int           m_cnt = 0;
  bit           m_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [LineW-1:0] got,
                          input logic [LineW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic byte unsigned m_digit(input int n);
    if (n < 10) return byte'(8'h30 + n);
`ifdef SIM_FMT_HEX_EN
    return byte'(8'h41 + n - 10);
`else
    return (n == 15) ? 8'h20 : 8'h3F;
`endif
  endfunction

  // Line built as a character list from the field rules, then padded/truncated to the width.
  function automatic logic [LineW-1:0] model_line(input int sel);
    byte unsigned q[$];
    string pfx;
    logic [LineW-1:0] line;
    int rec;
    rec = sel / 2;
    if (rec < NumRec) begin
      if (sel % 2 == 0) begin
        pfx = "Nombre: ";
        for (int i = 0; i < pfx.len(); i++) q.push_back(pfx[i]);
        for (int i = 0; i < NameLen; i++) begin
          int a;
          a = rec * RecBytes + NameOff + i;
          if (a >= m_cnt)              q.push_back(8'h2D);
          else if (m_mem[a] == 8'hFF)  q.push_back(8'h20);
          else                         q.push_back(m_mem[a]);
        end
      end else begin
        pfx = "#: ";
        for (int i = 0; i < pfx.len(); i++) q.push_back(pfx[i]);
        for (int i = 0; i < NumBytes; i++) begin
          int a;
          a = rec * RecBytes + NumOff + i;
          if (a >= m_cnt) begin
            q.push_back(8'h2D);
            q.push_back(8'h2D);
          end else begin
            q.push_back(m_digit(m_mem[a] % 16));
            q.push_back(m_digit(m_mem[a] / 16));
          end
        end
      end
    end
    line = '0;
    for (int i = 0; i < LcdChars; i++)
      line[LineW-1-8*i -: 8] = (i < q.size()) ? q[i] : 8'h20;
    return line;
  endfunction

  function automatic byte unsigned rand_byte();
    if ($urandom_range(0, 3) == 0) return 8'hFF;
    return byte'($urandom);
  endfunction

  task automatic send_byte(input byte unsigned b);
    @(posedge clk); #1;
    bus.Dato_SIM    = b;
    bus.Dato_Valido = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.Dato_Valido = 1'b0;
    repeat (3) @(posedge clk);
    if (m_cnt == Depth) m_ovf = 1'b1;
    else begin
      m_mem[m_cnt] = b;
      m_cnt++;
    end
  endtask

  task automatic clear_buf();
    @(posedge clk); #1 bus.Clear = 1'b1;
    @(posedge clk); #1 bus.Clear = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic run_fmt(input int sel, input string tag, output logic [LineW-1:0] line);
    int lat;
    bit seen;
    @(posedge clk); #1;
    bus.Sel = sel[1:0];
    bus.Req = 1'b1;
    @(posedge clk); #1 bus.Req = 1'b0;
    check_eq($sformatf("%s busy", tag), LineW'(bus.Ocupado), LineW'(1));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.Listo) seen = 1'b1;
    end
    check_eq($sformatf("%s latency", tag), LineW'(lat), LineW'(22));
    check_eq($sformatf("%s line", tag), bus.Dato_LCD, model_line(sel));
    line = bus.Dato_LCD;
    @(posedge clk); #1;
    check_eq($sformatf("%s listo pulse", tag), LineW'(bus.Listo), LineW'(0));
  endtask

  task automatic run_fmt3(input int sel, input string tag, input logic [LineW-1:0] exp);
    int lat;
    bit seen;
    @(posedge clk); #1;
    bus3.Sel = sel[2:0];
    bus3.Req = 1'b1;
    @(posedge clk); #1 bus3.Req = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus3.Listo) seen = 1'b1;
    end
    check_eq($sformatf("%s latency", tag), LineW'(lat), LineW'(22));
    check_eq($sformatf("%s line", tag), bus3.Dato_LCD, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LineW-1:0] line, exp, spaces;
    logic [8*NameLen-1:0] nm;
    byte unsigned numb [NumBytes];
    byte unsigned b;
    int listo_cnt, n;

    spaces = {LcdChars{8'h20}};
    nm     = {"JUAN PEREZ", 8'hFF, 8'hFF};
    numb   = '{8'h13, 8'h52, 8'h47, 8'h69, 8'hF0};
    bus.Dato_Valido = 1'b0; bus.Dato_SIM = '0; bus.Clear = 1'b0; bus.Req = 1'b0; bus.Sel = '0;
    bus3.Dato_Valido = 1'b0; bus3.Dato_SIM = '0; bus3.Clear = 1'b0; bus3.Req = 1'b0;
    bus3.Sel = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst lcd", bus.Dato_LCD, spaces);
    check_eq("rst flags", LineW'({bus.Listo, bus.Ocupado, bus.Desborde}), LineW'(0));
    check_eq("rst count", LineW'(bus.Bytes_Cont), LineW'(0));

    // Short stream, format, then reset in the middle of another byte.
    for (int i = 0; i < 5; i++) send_byte(byte'($urandom));
    run_fmt(0, "pre", line);
    @(posedge clk); #1 bus.Dato_SIM = 8'h55; bus.Dato_Valido = 1'b1;
    @(posedge clk); #3 rst_n = 1'b0;
    #2;
    check_eq("midrst lcd", bus.Dato_LCD, spaces);
    check_eq("midrst count", LineW'(bus.Bytes_Cont), LineW'(0));
    check_eq("midrst flags", LineW'({bus.Listo, bus.Ocupado, bus.Desborde}), LineW'(0));
    bus.Dato_Valido = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset while formatting: no Listo may follow.
    for (int i = 0; i < 3; i++) send_byte(byte'($urandom));
    @(posedge clk); #1 bus.Sel = '0; bus.Req = 1'b1;
    @(posedge clk); #1 bus.Req = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #2 check_eq("oprst busy", LineW'(bus.Ocupado), LineW'(0));
    m_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    listo_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.Listo) listo_cnt++;
    end
    check_eq("oprst no listo", LineW'(listo_cnt), LineW'(0));
    check_eq("oprst lcd", bus.Dato_LCD, spaces);

    // Full fill with the known name/number fields in record 0.
    for (int a = 0; a < Depth; a++) begin
      b = rand_byte();
      if (a >= 1 && a <= NameLen) b = nm[8*NameLen-1-8*(a-1) -: 8];
      if (a >= NumOff && a < NumOff + NumBytes) b = numb[a-NumOff];
      send_byte(b);
    end
    check_eq("full count", LineW'(bus.Bytes_Cont), LineW'(Depth));
    check_eq("full no ovf", LineW'(bus.Desborde), LineW'(0));
    run_fmt(0, "name0", line);
    exp = "Nombre: JUAN PEREZ  ";
    check_eq("name0 literal", line, exp);
    run_fmt(1, "num0", line);
`ifdef SIM_FMT_HEX_EN
    exp = "#: 312574960F       ";
`else
    exp = "#: 312574960        ";
`endif
    check_eq("num0 literal", line, exp);
    run_fmt(2, "name1", line);
    run_fmt(3, "num1", line);

    // Overflow, clear, and clear coincident with a capture edge.
    send_byte(8'h77);
    check_eq("ovf flag", LineW'(bus.Desborde), LineW'(1));
    check_eq("ovf count", LineW'(bus.Bytes_Cont), LineW'(Depth));
    clear_buf();
    check_eq("clr count", LineW'(bus.Bytes_Cont), LineW'(0));
    check_eq("clr ovf", LineW'(bus.Desborde), LineW'(0));
    send_byte(8'h11);
    send_byte(8'h22);
    @(posedge clk); #1 bus.Dato_SIM = 8'hA5; bus.Dato_Valido = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 bus.Clear = 1'b1;
    @(posedge clk); #1 bus.Clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.Dato_Valido = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_eq("clr wins", LineW'(bus.Bytes_Cont), LineW'(0));

    // Capture latency: count moves on the third edge after the strobe rises.
    @(posedge clk); #1 bus.Dato_SIM = 8'h3C; bus.Dato_Valido = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_eq("cap lat 2", LineW'(bus.Bytes_Cont), LineW'(0));
    @(posedge clk); #1 check_eq("cap lat 3", LineW'(bus.Bytes_Cont), LineW'(1));
    bus.Dato_Valido = 1'b0;
    m_mem[0] = 8'h3C;
    m_cnt = 1;
    repeat (3) @(posedge clk);

    // Partial second record: 35 bytes captured.
    while (m_cnt < 35) send_byte(rand_byte());
    run_fmt(2, "part name1", line);
    check_eq("part dashes", LineW'(line[63:0]), LineW'({8{8'h2D}}));
    run_fmt(3, "part num1", line);
    run_fmt(0, "part name0", line);

    // A second request while busy is ignored.
    @(posedge clk); #1 bus.Sel = 2'd0; bus.Req = 1'b1;
    @(posedge clk); #1 bus.Req = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.Sel = 2'd1; bus.Req = 1'b1;
    @(posedge clk); #1 bus.Req = 1'b0;
    listo_cnt = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.Listo) listo_cnt++;
    end
    check_eq("dbl req listo", LineW'(listo_cnt), LineW'(1));
    check_eq("dbl req line", bus.Dato_LCD, model_line(0));

    // Randomized fills and requests.
    for (int r = 0; r < 3; r++) begin
      clear_buf();
      n = $urandom_range(20, Depth);
      for (int i = 0; i < n; i++) send_byte(rand_byte());
      check_eq($sformatf("rnd%0d count", r), LineW'(bus.Bytes_Cont), LineW'(m_cnt));
      for (int k = 0; k < 3; k++) run_fmt($urandom_range(0, 3), $sformatf("rnd%0d_%0d", r, k), line);
    end

    // Out-of-range record on the three-record instance (empty buffer).
    exp = "Nombre: ------------";
    run_fmt3(0, "r3 name0", exp);
    run_fmt3(6, "r3 sel6", spaces);
    run_fmt3(0, "r3 name0 again", exp);
    run_fmt3(7, "r3 sel7", spaces);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
